seq_detect_prog: RTL and testbench
==================================

// Module: seq_detect_prog
// PURPOSE
//   Runtime-programmable serial bit-pattern detector; successor to the fixed
//   10111 Mealy detectors. Pattern, length (1..MAX_LEN) and overlap mode are
//   configured at runtime, input bits are qualified by x_valid, and matches are
//   counted. Sits on a serial bitstream (framing/sync-word search) with a
//   registered one-cycle match pulse.
// PARAMETERS
//   MAX_LEN          8          max pattern length in bits (>=2)
//   CNT_W            8          width of saturating match counter
//   DEFAULT_PATTERN  8'h17      pattern after reset (10111, LSB-aligned)
//   DEFAULT_LEN      5          pattern length after reset
//   DEFAULT_OVERLAP  1          overlap mode after reset (1=overlap)
// PORTS  (LEN_W = $clog2(MAX_LEN+1))
//   clk          in   1        clock, rising edge
//   rst          in   1        synchronous, active-high reset
//   cfg_load     in   1        strobe: latch cfg_* and clear history
//   cfg_pattern  in   MAX_LEN  pattern; bit[len-1]=first bit rx'd, bit[0]=last
//   cfg_len      in   LEN_W    pattern length
//   cfg_overlap  in   1        1=overlapping, 0=non-overlapping detection
//   x_valid      in   1        x is a valid stream bit this cycle
//   x            in   1        serial data bit
//   count_clr    in   1        clear match_count
//   y            out  1        match pulse, registered
//   match_count  out  CNT_W    matches since reset/clear, saturating
// BEHAVIOUR
//   - Reset: y=0, match_count=0, history=0, fill=0, pattern/len/overlap =
//     DEFAULT_*. rst overrides every other input, including mid-stream.
//   - Accepting edge = rising clk with x_valid=1 and cfg_load=0.
//     hist <= {hist[MAX_LEN-2:0], x}; fill <= min(fill+1, MAX_LEN).
//   - Match on accepting edge iff (fill+1 >= len) and new hist[len-1:0] ==
//     pattern[len-1:0]. Bits above len are ignored in compare.
//   - y (Mealy, registered): y=1 in the cycle after the accepting edge that
//     completes the match; y=0 on every other edge, including x_valid=0 edges.
//     Latency 1 clk from last bit; back-to-back matches give y high on
//     consecutive cycles.
//   - Overlap=1: fill is not reset on a match (full self-overlap; any
//     suffix/prefix border is reused).
//   - Overlap=0: on match fill <= 0, so the next match needs len fresh bits.
//   - cfg_load: latches pattern/len/overlap, hist<=0, fill<=0, y<=0. Same-cycle
//     x_valid bit is discarded. match_count is unaffected.
//   - cfg_len clamp at load: 0 -> 1, >MAX_LEN -> MAX_LEN.
//   - match_count: +1 per match, saturates at 2^CNT_W-1 (no wrap).
//     count_clr alone -> 0; count_clr with match on the same edge -> 1.
//   - No state machine beyond hist/fill registers; all logic is
//     single-clock, no combinational path from inputs to outputs.
// TESTING
//   1. Reset defaults, overlap=1, bits 1,0,1,1,1,0,1,1,1 -> y pulses after
//      bits 5 and 9; match_count=2.
//   2. Load 10111/len5/overlap=0, same stream -> y only after bit 5; count=1.
//   3. Load pattern 11, len2: overlap=1 on 1,1,1,1 -> y after bits 2,3,4;
//      overlap=0 -> y after bits 2,4.
//   4. x_valid gaps: 1,0,_,1,1,_,_,1 (_ = x_valid=0, x toggling) -> single y
//      pulse after final 1; y=0 during gaps.
//   5. cfg_load with x_valid=1 after 1011 received -> next bit 1 gives no
//      match; cfg_len=0 loads as 1; cfg_len=15 with MAX_LEN=8 loads as 8.
//   6. CNT_W=2: 5 matches -> match_count=3; count_clr on a match edge -> 1;
//      rst mid-pattern (after 101) then 11 -> no match.

Source files
------------

// File: rtl/seq_detect_prog_if.sv
// Bus bundle for the programmable serial pattern detector: configuration,
// qualified serial input, counter clear and the match outputs.
interface seq_detect_prog_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               x_valid;
    logic               x;
    logic               count_clr;
    logic               y;
    logic [CNT_W-1:0]   match_count;

    // Stream/config source side
    modport master (
        output cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        output x_valid, x, count_clr,
        input  y, match_count
    );

    // Detector side
    modport slave (
        input  cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        input  x_valid, x, count_clr,
        output y, match_count
    );
endinterface

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial bit-pattern detector. Shifts qualified bits into
// a history register, compares the newest len bits against the programmed
// pattern, emits a registered one-cycle match pulse and counts matches with a
// saturating counter.
module seq_detect_prog #(
    parameter int                 MAX_LEN         = 8,
    parameter int                 CNT_W           = 8,
    parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = 'h17,
    parameter int                 DEFAULT_LEN     = 5,
    parameter bit                 DEFAULT_OVERLAP = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    seq_detect_prog_if.slave  bus
);
    localparam int                 LEN_W    = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0]   FILL_MAX = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

    typedef struct packed {
        logic [MAX_LEN-1:0] pattern;
        logic [LEN_W-1:0]   len;
        logic               overlap;
    } cfg_t;

    cfg_t               cfg;
    logic [MAX_LEN-1:0] hist, hist_nxt, len_mask;
    logic [LEN_W-1:0]   fill, fill_nxt, len_clamped;
    logic [LEN_W:0]     fill_p1;
    logic               accept, match;
    logic               y_q;
    logic [CNT_W-1:0]   cnt_q;

    // Clamp the requested length into 1..MAX_LEN so the compare is never empty
    always_comb begin
        len_clamped = bus.cfg_len;
        if (bus.cfg_len == '0)
            len_clamped = LEN_W'(1);
        else if (bus.cfg_len > FILL_MAX)
            len_clamped = FILL_MAX;
    end

    // Compare mask: only the low len bits of history/pattern participate
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            len_mask[i] = (i < int'(cfg.len));
    end

    // Accept/match decode and next fill; fill tracks how many bits are usable
    always_comb begin
        accept   = bus.x_valid & ~bus.cfg_load;
        hist_nxt = {hist[MAX_LEN-2:0], bus.x};
        fill_p1  = {1'b0, fill} + (LEN_W+1)'(1);
        match    = accept && (fill_p1 >= {1'b0, cfg.len}) &&
                   (((hist_nxt ^ cfg.pattern) & len_mask) == '0);
        fill_nxt = fill;
        if (accept) begin
            if (match && !cfg.overlap)
                fill_nxt = '0;
            else if (fill != FILL_MAX)
                fill_nxt = fill + LEN_W'(1);
        end
    end

    // Config, history, fill and match pulse; a load flushes history and drops
    // the same-cycle bit
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg  <= '{pattern: DEFAULT_PATTERN, len: LEN_W'(DEFAULT_LEN),
                      overlap: DEFAULT_OVERLAP};
            hist <= '0;
            fill <= '0;
            y_q  <= 1'b0;
        end else if (bus.cfg_load) begin
            cfg  <= '{pattern: bus.cfg_pattern, len: len_clamped,
                      overlap: bus.cfg_overlap};
            hist <= '0;
            fill <= '0;
            y_q  <= 1'b0;
        end else begin
            if (accept)
                hist <= hist_nxt;
            fill <= fill_nxt;
            y_q  <= match;
        end
    end

    // Saturating match counter; a clear coinciding with a match leaves 1
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (bus.count_clr)
            cnt_q <= match ? CNT_W'(1) : '0;
        else if (match && cnt_q != CNT_MAX)
            cnt_q <= cnt_q + CNT_W'(1);
    end

    assign bus.y           = y_q;
    assign bus.match_count = cnt_q;
endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: directed vector tables for the documented
// scenarios, then randomized traffic checked against a queue-based model.
// A second instance with a 2-bit counter shares all stimulus to observe
// counter saturation.
module tb_seq_detect_prog;
    localparam int MAX_LEN = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_detect_prog_if #(.MAX_LEN(MAX_LEN), .CNT_W(8)) b ();
    seq_detect_prog_if #(.MAX_LEN(MAX_LEN), .CNT_W(2)) b2 ();

    assign b2.cfg_load    = b.cfg_load;
    assign b2.cfg_pattern = b.cfg_pattern;
    assign b2.cfg_len     = b.cfg_len;
    assign b2.cfg_overlap = b.cfg_overlap;
    assign b2.x_valid     = b.x_valid;
    assign b2.x           = b.x;
    assign b2.count_clr   = b.count_clr;

    seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(8), .DEFAULT_PATTERN(8'h17),
                      .DEFAULT_LEN(5), .DEFAULT_OVERLAP(1'b1))
        dut (.clk(clk), .rst(rst), .bus(b.slave));

    seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(2), .DEFAULT_PATTERN(8'h17),
                      .DEFAULT_LEN(5), .DEFAULT_OVERLAP(1'b1))
        dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

    int checks = 0;
    int errors = 0;

    // Reference model: bits since the last history flush, newest at the back
    bit       mq[$];
    bit [7:0] mpat;
    int       mlen;
    bit       movl;
    bit       ey;
    int       ec8, ec2;

    typedef struct {
        bit xv;
        bit x;
        bit ey;
    } vec_t;
    vec_t tq[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic bit model_hit();
        if (mq.size() < mlen) return 1'b0;
        for (int k = 0; k < mlen; k++)
            if (mq[mq.size()-1-k] != mpat[k]) return 1'b0;
        return 1'b1;
    endfunction

    // One clock: drive inputs, take the edge, advance the model
    task automatic cyc(input bit r, input bit ld, input logic [7:0] p, input logic [3:0] l,
                       input bit o, input bit xv, input bit xx, input bit clr);
        bit hit;
        rst           = r;
        b.cfg_load    = ld;
        b.cfg_pattern = p;
        b.cfg_len     = l;
        b.cfg_overlap = o;
        b.x_valid     = xv;
        b.x           = xx;
        b.count_clr   = clr;
        @(posedge clk);
        #1;
        hit = 1'b0;
        if (r) begin
            mq.delete();
            mpat = 8'h17; mlen = 5; movl = 1'b1;
            ec8 = 0; ec2 = 0;
        end else begin
            if (ld) begin
                mpat = p;
                mlen = (l == 0) ? 1 : ((int'(l) > MAX_LEN) ? MAX_LEN : int'(l));
                movl = o;
                mq.delete();
            end else if (xv) begin
                mq.push_back(xx);
                if (mq.size() > MAX_LEN) void'(mq.pop_front());
                hit = model_hit();
                if (hit && !movl) mq.delete();
            end
            if (clr) begin
                ec8 = hit; ec2 = hit;
            end else if (hit) begin
                if (ec8 < 255) ec8++;
                if (ec2 < 3) ec2++;
            end
        end
        ey = hit;
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input bit o);
        cyc(1'b0, 1'b1, p, l, o, 1'b0, 1'b0, 1'b0);
    endtask

    // xs: '1'/'0' valid bits, '_' gap with x toggling; ys: expected y per cycle
    task automatic add_str(input string xs, input string ys);
        for (int i = 0; i < xs.len(); i++)
            tq.push_back('{xs[i] != "_", (xs[i] == "_") ? bit'(i % 2) : (xs[i] == "1"),
                           ys[i] == "1"});
    endtask

    task automatic run(input int from, input string tag);
        for (int i = from; i < tq.size(); i++) begin
            cyc(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, tq[i].xv, tq[i].x, 1'b0);
            check($sformatf("%s[%0d] y", tag, i - from), b.y, tq[i].ey);
        end
    endtask

    task automatic counts(input string tag, input int e8, input int e2);
        check({tag, " count8"}, b.match_count, e8);
        check({tag, " count2"}, b2.match_count, e2);
    endtask

    initial begin
        int s;
        // Reset asserted together with every other input: reset must win
        cyc(1'b1, 1'b1, 8'h00, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 8'h00, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1);
        check("reset y", b.y, 0);
        counts("reset", 0, 0);

        // Defaults: 10111, overlap
        s = tq.size(); add_str("101110111", "000010001"); run(s, "t1");
        counts("t1", 2, 2);

        // Non-overlapping 10111
        load(8'h17, 4'd5, 1'b0);
        counts("t2 load keeps count", 2, 2);
        s = tq.size(); add_str("101110111", "000010000"); run(s, "t2");
        counts("t2", 3, 3);

        // Pattern 11 with junk above len
        load(8'hF3, 4'd2, 1'b1);
        s = tq.size(); add_str("1111", "0111"); run(s, "t3ov");
        load(8'hF3, 4'd2, 1'b0);
        s = tq.size(); add_str("1111", "0101"); run(s, "t3no");
        counts("t3", 8, 3);

        // Valid gaps
        load(8'h17, 4'd5, 1'b1);
        s = tq.size(); add_str("10_11__1", "00000001"); run(s, "t4");
        counts("t4", 9, 3);

        // Load flushes history and drops same-cycle bit
        s = tq.size(); add_str("1011", "0000"); run(s, "t5pre");
        cyc(1'b0, 1'b1, 8'h17, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        check("t5 load y", b.y, 0);
        s = tq.size(); add_str("1", "0"); run(s, "t5post");
        // Length clamps
        load(8'hFE, 4'd0, 1'b1);
        s = tq.size(); add_str("010", "101"); run(s, "t5len0");
        load(8'hA5, 4'd15, 1'b1);
        s = tq.size(); add_str("10100101", "00000001"); run(s, "t5len15");
        counts("t5", 12, 3);

        // Counter clear and saturation
        cyc(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        counts("t6 clr", 0, 0);
        load(8'h03, 4'd2, 1'b1);
        s = tq.size(); add_str("111111", "011111"); run(s, "t6sat");
        counts("t6 sat", 5, 3);
        cyc(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("t6 clr+match y", b.y, 1);
        counts("t6 clr+match", 1, 1);
        // Reset mid-pattern
        load(8'h17, 4'd5, 1'b1);
        s = tq.size(); add_str("101", "000"); run(s, "t6pre");
        cyc(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t6 rst y", b.y, 0);
        counts("t6 rst", 0, 0);
        s = tq.size(); add_str("11", "00"); run(s, "t6post");

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bit r, ld, o, xv, xx, clr;
            logic [7:0] p;
            logic [3:0] l;
            r   = ($urandom_range(0, 199) == 0);
            ld  = ($urandom_range(0, 39) == 0);
            p   = 8'($urandom);
            l   = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 4)) : 4'($urandom_range(0, 15));
            o   = 1'($urandom_range(0, 1));
            xv  = ($urandom_range(0, 3) != 0);
            xx  = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 63) == 0);
            cyc(r, ld, p, l, o, xv, xx, clr);
            check($sformatf("rnd[%0d] y", n), b.y, ey);
            check($sformatf("rnd[%0d] count8", n), b.match_count, ec8);
            check($sformatf("rnd[%0d] count2", n), b2.match_count, ec2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
